// File: rtl/refresh_sched_if.sv
// Refresh scheduler bus: grant/clear from the controller FSM, command
// handshake to the cmd mux, and status back to the controller.
interface refresh_sched_if;
    logic       clear_refresh;
    logic       busy;
    logic       ref_cmd_ack;
    logic       refresh_almost;
    logic       refresh_done;
    logic       ref_cmd_valid;
    logic       ref_cmd_type;
    logic [3:0] refresh_debt;
    logic       refresh_overflow;

    // Scheduler side
    modport master (
        input  clear_refresh,
        input  busy,
        input  ref_cmd_ack,
        output refresh_almost,
        output refresh_done,
        output ref_cmd_valid,
        output ref_cmd_type,
        output refresh_debt,
        output refresh_overflow
    );

    // Controller FSM / cmd mux side
    modport slave (
        output clear_refresh,
        output busy,
        output ref_cmd_ack,
        input  refresh_almost,
        input  refresh_done,
        input  ref_cmd_valid,
        input  ref_cmd_type,
        input  refresh_debt,
        input  refresh_overflow
    );
endinterface

// File: rtl/refresh_sched.sv
// Refresh scheduler: tREFI interval counter with postponed-refresh debt,
// and a PREA -> tRP -> REF (xN, tRFC each) sequencer run once granted.
module refresh_sched #(
    parameter int T_REFI       = 7800,
    parameter int T_RP         = 14,
    parameter int T_RFC        = 350,
    parameter int ALMOST_LEAD  = 64,
    parameter int MAX_POSTPONE = 8,
    parameter int CNT_W        = 16
) (
    input  logic               CK_t,
    input  logic               reset_n,
    refresh_sched_if.master    bus
);

    localparam logic [CNT_W-1:0] REFI_LAST = CNT_W'(T_REFI - 1);
    localparam logic [CNT_W-1:0] ALMOST_AT = CNT_W'(T_REFI - ALMOST_LEAD);
    localparam logic [CNT_W-1:0] TRP_LAST  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] TRFC_LAST = CNT_W'(T_RFC - 1);
    localparam logic [3:0]       DEBT_MAX  = 4'(MAX_POSTPONE);

    typedef enum logic [2:0] {
        R_IDLE,
        R_PREA,
        R_TRP,
        R_REF,
        R_TRFC,
        R_DONE
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] refi_cnt, refi_cnt_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [3:0]       debt, debt_next;
    logic [3:0]       rem;
    logic             almost_q;
    logic             overflow_q;
    logic             ovf_set;
    logic             expire;
    logic             ref_ack;
    logic             cmd_valid;
    logic             cmd_type;
    logic             done;
    logic             wait_clr;
    logic             rem_load;
    logic             rem_dec;

    assign expire  = (refi_cnt == REFI_LAST);
    // valid is always high in R_REF, so a raw ack there is a real acceptance
    assign ref_ack = (state == R_REF) && bus.ref_cmd_ack;

    // Interval counter and debt bookkeeping for the next cycle
    always_comb begin
        refi_cnt_next = refi_cnt + 1'b1;
        debt_next     = debt;
        ovf_set       = 1'b0;
        if ((state == R_IDLE) && bus.clear_refresh) begin
            refi_cnt_next = '0;
            debt_next     = '0;
        end else begin
            if (expire) begin
                refi_cnt_next = '0;
            end
            if (ref_ack && expire) begin
                // owed one more and paid one: debt unchanged
                debt_next = debt;
            end else if (ref_ack) begin
                if (debt != '0) begin
                    debt_next = debt - 1'b1;
                end else begin
                    // pulled-in refresh: the interval restarts from here
                    refi_cnt_next = '0;
                end
            end else if (expire) begin
                if (debt == DEBT_MAX) begin
                    ovf_set = 1'b1;
                end else begin
                    debt_next = debt + 1'b1;
                end
            end
        end
    end

    // Interval, debt, almost and sticky overflow registers
    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            refi_cnt   <= '0;
            debt       <= '0;
            almost_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            refi_cnt   <= refi_cnt_next;
            debt       <= debt_next;
            almost_q   <= (debt_next != '0) || (refi_cnt_next >= ALMOST_AT);
            overflow_q <= overflow_q | ovf_set;
        end
    end

    // Sequencer state register
    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            state <= R_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sequencer next state, command outputs and datapath controls
    always_comb begin
        state_next = state;
        cmd_valid  = 1'b0;
        cmd_type   = 1'b0;
        done       = 1'b0;
        wait_clr   = 1'b0;
        rem_load   = 1'b0;
        rem_dec    = 1'b0;
        case (state)
            R_IDLE: begin
                if (bus.busy && almost_q) begin
                    rem_load   = 1'b1;
                    state_next = R_PREA;
                end
            end
            R_PREA: begin
                cmd_valid = 1'b1;
                if (bus.ref_cmd_ack) begin
                    wait_clr   = 1'b1;
                    state_next = R_TRP;
                end
            end
            R_TRP: begin
                if (wait_cnt == TRP_LAST) begin
                    state_next = R_REF;
                end
            end
            R_REF: begin
                cmd_valid = 1'b1;
                cmd_type  = 1'b1;
                if (bus.ref_cmd_ack) begin
                    wait_clr   = 1'b1;
                    rem_dec    = 1'b1;
                    state_next = R_TRFC;
                end
            end
            R_TRFC: begin
                if (wait_cnt == TRFC_LAST) begin
                    state_next = (rem != '0) ? R_REF : R_DONE;
                end
            end
            R_DONE: begin
                done       = 1'b1;
                state_next = R_IDLE;
            end
            default: begin
                state_next = R_IDLE;
            end
        endcase
    end

    // Wait-cycle counter and remaining-REF count for the current sequence
    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
            rem      <= '0;
        end else begin
            if (wait_clr) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (rem_load) begin
                rem <= (debt == '0) ? 4'd1 : debt;
            end else if (rem_dec) begin
                rem <= rem - 1'b1;
            end
        end
    end

    assign bus.refresh_almost   = almost_q;
    assign bus.refresh_done     = done;
    assign bus.ref_cmd_valid    = cmd_valid;
    assign bus.ref_cmd_type     = cmd_type;
    assign bus.refresh_debt     = debt;
    assign bus.refresh_overflow = overflow_q;

endmodule

// File: tb/tb_refresh_sched.sv
// Directed bench for refresh_sched with small timing parameters.
module tb_refresh_sched;

    logic CK_t;
    logic reset_n;

    refresh_sched_if bus ();

    refresh_sched #(
        .T_REFI      (100),
        .T_RP        (3),
        .T_RFC       (10),
        .ALMOST_LEAD (8),
        .MAX_POSTPONE(8),
        .CNT_W       (16)
    ) dut (
        .CK_t   (CK_t),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial CK_t = 1'b0;
    always #5 CK_t = ~CK_t;

    typedef struct {
        bit       clr;
        bit       busy;
        bit       ack;
        int       n;
        bit       alm;
        bit [3:0] debt;
        bit       vld;
        bit       typ;
        bit       done;
        bit       ovf;
    } vec_t;

    vec_t vec[$];
    int total = 0;
    int bad   = 0;

    task automatic r(input bit clr, input bit busy, input bit ack, input int n,
                     input bit alm, input bit [3:0] debt, input bit vld,
                     input bit typ, input bit done, input bit ovf);
        vec_t v;
        v = '{clr, busy, ack, n, alm, debt, vld, typ, done, ovf};
        vec.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, ".almost"},   int'(bus.refresh_almost),   int'(v.alm));
        chk({tag, ".debt"},     int'(bus.refresh_debt),     int'(v.debt));
        chk({tag, ".valid"},    int'(bus.ref_cmd_valid),    int'(v.vld));
        chk({tag, ".done"},     int'(bus.refresh_done),     int'(v.done));
        chk({tag, ".overflow"}, int'(bus.refresh_overflow), int'(v.ovf));
        if (v.vld) chk({tag, ".type"}, int'(bus.ref_cmd_type), int'(v.typ));
    endtask

    initial begin
        vec_t zero;
        int   cyc;
        bit   seen_cmd;

        // clr busy ack n | almost debt valid type done ovf
        // init hold
        r(1,0,0, 20,  0,0,0,0,0,0);
        // interval: almost at cnt 92, debt at expiry
        r(0,0,0, 91,  0,0,0,0,0,0);
        r(0,0,0, 1,   1,0,0,0,0,0);
        r(0,0,0, 7,   1,0,0,0,0,0);
        r(0,0,0, 1,   1,1,0,0,0,0);
        // single refresh, immediate acks
        r(0,1,0, 1,   1,1,1,0,0,0);
        r(0,0,1, 1,   1,1,0,0,0,0);
        r(0,0,1, 3,   1,1,1,1,0,0);
        r(0,0,1, 1,   0,0,0,0,0,0);
        r(0,0,1, 9,   0,0,0,0,0,0);
        r(0,0,1, 1,   0,0,0,0,1,0);
        r(0,0,1, 1,   0,0,0,0,0,0);
        // build debt 3, PREA ack withheld 5 cycles (clear ignored outside idle)
        r(0,0,0, 83,  1,1,0,0,0,0);
        r(0,0,0, 200, 1,3,0,0,0,0);
        r(0,1,0, 1,   1,3,1,0,0,0);
        r(1,0,0, 5,   1,3,1,0,0,0);
        r(0,0,1, 1,   1,3,0,0,0,0);
        r(0,0,1, 2,   1,3,0,0,0,0);
        r(0,0,1, 1,   1,3,1,1,0,0);
        r(0,0,1, 1,   1,2,0,0,0,0);
        r(0,0,1, 9,   1,2,0,0,0,0);
        r(0,0,1, 1,   1,2,1,1,0,0);
        r(0,0,1, 1,   1,1,0,0,0,0);
        r(0,0,1, 10,  1,1,1,1,0,0);
        r(0,0,1, 1,   0,0,0,0,0,0);
        r(0,0,1, 9,   0,0,0,0,0,0);
        r(0,0,1, 1,   0,0,0,0,1,0);
        r(0,0,0, 1,   0,0,0,0,0,0);
        // saturation and sticky overflow
        r(0,0,0, 56,  1,1,0,0,0,0);
        r(0,0,0, 600, 1,7,0,0,0,0);
        r(0,0,0, 100, 1,8,0,0,0,0);
        r(0,0,0, 99,  1,8,0,0,0,0);
        r(0,0,0, 1,   1,8,0,0,0,1);
        r(0,0,0, 100, 1,8,0,0,0,1);
        // clear in idle drops debt, overflow stays
        r(1,0,0, 1,   0,0,0,0,0,1);
        // pulled-in refresh with zero debt restarts the interval
        r(0,0,0, 91,  0,0,0,0,0,1);
        r(0,0,0, 1,   1,0,0,0,0,1);
        r(0,1,0, 1,   1,0,1,0,0,1);
        r(0,0,1, 4,   1,0,1,1,0,1);
        r(0,0,1, 1,   0,0,0,0,0,1);

        reset_n           = 1'b0;
        bus.clear_refresh = 1'b1;
        bus.busy          = 1'b0;
        bus.ref_cmd_ack   = 1'b0;
        repeat (2) @(posedge CK_t);
        #1;
        zero = '{0,0,0,0,0,0,0,0,0,0};
        chk_all("reset", zero);
        reset_n = 1'b1;

        foreach (vec[i]) begin
            bus.clear_refresh = vec[i].clr;
            bus.busy          = vec[i].busy;
            bus.ref_cmd_ack   = vec[i].ack;
            repeat (vec[i].n) @(posedge CK_t);
            #1;
            chk_all($sformatf("row%0d", i), vec[i]);
        end

        // async reset in the middle of tRFC
        repeat (4) @(posedge CK_t);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all("trfc_reset", zero);
        bus.clear_refresh = 1'b0;
        bus.busy          = 1'b0;
        bus.ref_cmd_ack   = 1'b0;
        @(negedge CK_t);
        reset_n = 1'b1;

        // after reset the interval restarts from zero; no sequence resumes
        cyc      = 0;
        seen_cmd = 1'b0;
        while (!bus.refresh_almost && cyc < 200) begin
            @(posedge CK_t);
            #1;
            cyc++;
            if (bus.ref_cmd_valid || bus.refresh_done) seen_cmd = 1'b1;
        end
        chk("post_reset_almost_cycle", cyc, 92);
        chk("post_reset_no_cmd", int'(seen_cmd), 0);
        chk("post_reset_debt", int'(bus.refresh_debt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
